capture_controller: RTL and testbench

- Sequencer sitting directly upstream of the sample SRAM interface; owns both its write port (mwr_*) and its read port (mrd_*).
- When armed, streams sample words into memory continuously until a trigger. It then stores a configured number of post-trigger samples and marks the last one with mwr_tlast.
- It then reads a configured number of words back from memory and presents each one to the transmitter over a valid/ready handshake.

---
 rtl/capture_controller.sv | 215 +++++++++++++++++++++
 tb/tb_capture_controller.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_controller.sv
// capture_controller
// Sequences a sample capture into the sample SRAM and reads it back out to
// the transmitter.
//   arm      : snapshot configuration and start streaming samples (IDLE only)
//   run      : trigger level; after it, cfg_fwd+1 more samples are stored,
//              the last marked with mwr_tlast
//   readback : cfg_rd+1 words are read from memory and handed to the
//              transmitter one at a time over tx_tvalid/tx_tready
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_wr, cfg_fwd, cfg_rd  configuration load strobe and counts (minus one)
//   arm, abort, run          control inputs
//   sti_tvalid, sti_tdata    sample stream in
//   mwr_tvalid/tlast/tdata   memory write port (registered)
//   mrd_tready               one-cycle pulse stepping the memory read address
//   mrd_tvalid/tkeep/tdata   memory read data
//   tx_tvalid/tkeep/tdata    word to transmitter, tx_tready accepts it
//   busy, done               status; done pulses once at end of read-back
module capture_controller #(
    parameter int unsigned MDW = 32,
    parameter int unsigned CW  = 16,
    parameter int unsigned MRL = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_wr,
    input  logic [CW-1:0]   cfg_fwd,
    input  logic [CW-1:0]   cfg_rd,
    input  logic            arm,
    input  logic            abort,
    input  logic            run,
    input  logic            sti_tvalid,
    input  logic [MDW-1:0]  sti_tdata,
    output logic            mwr_tvalid,
    output logic            mwr_tlast,
    output logic [MDW-1:0]  mwr_tdata,
    output logic            mrd_tready,
    input  logic            mrd_tvalid,
    input  logic [3:0]      mrd_tkeep,
    input  logic [MDW-1:0]  mrd_tdata,
    output logic            tx_tvalid,
    output logic [3:0]      tx_tkeep,
    output logic [MDW-1:0]  tx_tdata,
    input  logic            tx_tready,
    output logic            busy,
    output logic            done
);

    localparam int unsigned LW = (MRL > 1) ? $clog2(MRL) : 1;
    localparam logic [LW-1:0] LAT_LOAD = LW'(MRL - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_DELAY,
        ST_RDWAIT,
        ST_TX
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   fwd_cfg, fwd_cfg_d;
    logic [CW-1:0]   rd_cfg, rd_cfg_d;
    logic [CW-1:0]   fwd_left, fwd_left_d;
    logic [CW-1:0]   rd_left, rd_left_d;
    logic [LW-1:0]   lat_cnt, lat_cnt_d;
    logic            mwr_tvalid_d;
    logic            mwr_tlast_d;
    logic [MDW-1:0]  mwr_tdata_d;
    logic            mrd_tready_d;
    logic            tx_tvalid_d;
    logic [3:0]      tx_tkeep_d;
    logic [MDW-1:0]  tx_tdata_d;
    logic            busy_d;
    logic            done_d;

    // Read data is captured purely on the fixed memory latency.
    logic            unused_mrd_tvalid;
    assign unused_mrd_tvalid = mrd_tvalid;

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            fwd_cfg    <= '0;
            rd_cfg     <= '0;
            fwd_left   <= '0;
            rd_left    <= '0;
            lat_cnt    <= '0;
            mwr_tvalid <= 1'b0;
            mwr_tlast  <= 1'b0;
            mwr_tdata  <= '0;
            mrd_tready <= 1'b0;
            tx_tvalid  <= 1'b0;
            tx_tkeep   <= '0;
            tx_tdata   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            fwd_cfg    <= fwd_cfg_d;
            rd_cfg     <= rd_cfg_d;
            fwd_left   <= fwd_left_d;
            rd_left    <= rd_left_d;
            lat_cnt    <= lat_cnt_d;
            mwr_tvalid <= mwr_tvalid_d;
            mwr_tlast  <= mwr_tlast_d;
            mwr_tdata  <= mwr_tdata_d;
            mrd_tready <= mrd_tready_d;
            tx_tvalid  <= tx_tvalid_d;
            tx_tkeep   <= tx_tkeep_d;
            tx_tdata   <= tx_tdata_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        fwd_cfg_d    = fwd_cfg;
        rd_cfg_d     = rd_cfg;
        fwd_left_d   = fwd_left;
        rd_left_d    = rd_left;
        lat_cnt_d    = lat_cnt;
        mwr_tvalid_d = 1'b0;
        mwr_tlast_d  = 1'b0;
        mwr_tdata_d  = mwr_tdata;
        mrd_tready_d = 1'b0;
        tx_tvalid_d  = tx_tvalid;
        tx_tkeep_d   = tx_tkeep;
        tx_tdata_d   = tx_tdata;
        done_d       = 1'b0;

        // Configuration only feeds the working counters at arm time.
        if (cfg_wr) begin
            fwd_cfg_d = cfg_fwd;
            rd_cfg_d  = cfg_rd;
        end

        if (abort && (state != ST_IDLE)) begin
            // Abort wins over any sample, trigger or handshake this cycle.
            state_d     = ST_IDLE;
            tx_tvalid_d = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state_d    = ST_SAMPLE;
                        fwd_left_d = fwd_cfg;
                        rd_left_d  = rd_cfg;
                    end
                end

                ST_SAMPLE: begin
                    // A sample coinciding with the trigger is pre-trigger.
                    if (sti_tvalid) begin
                        mwr_tvalid_d = 1'b1;
                        mwr_tdata_d  = sti_tdata;
                    end
                    if (run) begin
                        state_d = ST_DELAY;
                    end
                end

                ST_DELAY: begin
                    if (sti_tvalid) begin
                        mwr_tvalid_d = 1'b1;
                        mwr_tdata_d  = sti_tdata;
                        if (fwd_left == '0) begin
                            mwr_tlast_d = 1'b1;
                            lat_cnt_d   = LAT_LOAD;
                            state_d     = ST_RDWAIT;
                        end else begin
                            fwd_left_d = fwd_left - CW'(1);
                        end
                    end
                end

                ST_RDWAIT: begin
                    // Address is held; wait out the memory read latency.
                    if (lat_cnt == '0) begin
                        tx_tvalid_d = 1'b1;
                        tx_tdata_d  = mrd_tdata;
                        tx_tkeep_d  = mrd_tkeep;
                        state_d     = ST_TX;
                    end else begin
                        lat_cnt_d = lat_cnt - LW'(1);
                    end
                end

                ST_TX: begin
                    if (tx_tready) begin
                        tx_tvalid_d = 1'b0;
                        if (rd_left == '0) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            rd_left_d    = rd_left - CW'(1);
                            mrd_tready_d = 1'b1;
                            lat_cnt_d    = LAT_LOAD;
                            state_d      = ST_RDWAIT;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_capture_controller.sv
// Randomized scoreboard bench for capture_controller with an SRAM model.
module tb_capture_controller;

    localparam int unsigned MDW   = 32;
    localparam int unsigned CW    = 16;
    localparam int unsigned MRL   = 2;
    localparam int unsigned DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_wr = 1'b0;
    logic [CW-1:0]   cfg_fwd = '0;
    logic [CW-1:0]   cfg_rd = '0;
    logic            arm = 1'b0;
    logic            abort = 1'b0;
    logic            run = 1'b0;
    logic            sti_tvalid = 1'b0;
    logic [MDW-1:0]  sti_tdata = '0;
    logic            mwr_tvalid, mwr_tlast, mrd_tready, mrd_tvalid;
    logic [MDW-1:0]  mwr_tdata, mrd_tdata, tx_tdata;
    logic [3:0]      mrd_tkeep, tx_tkeep;
    logic            tx_tvalid, busy, done;
    logic            tx_tready = 1'b0;

    capture_controller #(.MDW(MDW), .CW(CW), .MRL(MRL)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_fwd(cfg_fwd), .cfg_rd(cfg_rd),
        .arm(arm), .abort(abort), .run(run),
        .sti_tvalid(sti_tvalid), .sti_tdata(sti_tdata),
        .mwr_tvalid(mwr_tvalid), .mwr_tlast(mwr_tlast), .mwr_tdata(mwr_tdata),
        .mrd_tready(mrd_tready), .mrd_tvalid(mrd_tvalid), .mrd_tkeep(mrd_tkeep),
        .mrd_tdata(mrd_tdata),
        .tx_tvalid(tx_tvalid), .tx_tkeep(tx_tkeep), .tx_tdata(tx_tdata),
        .tx_tready(tx_tready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // SRAM model: ring buffer, read pointer follows the write pointer and
    // steps on mrd_tready; data appears one edge after the address moves.
    logic [MDW-1:0]  mem [DEPTH];
    int unsigned     wa = 0;
    int unsigned     ra = 0;
    logic            mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
            mem_ready <= 1'b1;
        end else if (mwr_tvalid) begin
            mem[wa] <= mwr_tdata;
            wa      <= (wa + 1) % DEPTH;
            ra      <= (wa + 1) % DEPTH;
        end else if (mrd_tready) begin
            ra <= (ra + 1) % DEPTH;
        end
    end

    assign mrd_tdata  = mem[ra];
    assign mrd_tkeep  = 4'h7;
    assign mrd_tvalid = 1'b1;

    // Reference model state and scoreboard queues.
    typedef struct packed { logic [MDW-1:0] data; logic last; } wr_t;
    typedef struct packed { logic [MDW-1:0] data; logic [3:0] keep; } tx_t;

    wr_t             exp_wr[$];
    tx_t             exp_tx[$];
    logic [MDW-1:0]  model_mem [DEPTH];
    int unsigned     model_wa = 0;
    int              m_fwd = 0;
    int              m_rd  = 0;

    int              checks = 0;
    int              failures = 0;
    int              done_cnt = 0;
    int              pulse_cnt = 0;
    bit              mon_en = 0;
    bit              in_rb = 0;
    wr_t             mon_wr;
    tx_t             mon_tx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [MDW-1:0] d, input logic last);
        exp_wr.push_back('{data: d, last: last});
        model_mem[model_wa] = d;
        model_wa = (model_wa + 1) % DEPTH;
    endtask

    task automatic do_cfg(input int f, input int r);
        cfg_wr  = 1'b1;
        cfg_fwd = CW'(f);
        cfg_rd  = CW'(r);
        tick();
        cfg_wr = 1'b0;
        m_fwd  = f;
        m_rd   = r;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_mwr_tvalid"}, 64'(mwr_tvalid), 64'd0);
        check({tag, "_mwr_tlast"}, 64'(mwr_tlast), 64'd0);
        check({tag, "_mrd_tready"}, 64'(mrd_tready), 64'd0);
        check({tag, "_tx_tvalid"}, 64'(tx_tvalid), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // Monitor: pops expected writes/words whenever the DUT presents them.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mwr_tvalid) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_wr = exp_wr.pop_front();
                    check("wr_data", 64'(mwr_tdata), 64'(mon_wr.data));
                    check("wr_last", 64'(mwr_tlast), 64'(mon_wr.last));
                end
                check("wr_rd_exclusive", 64'(mrd_tready), 64'd0);
            end
            if (tx_tvalid && tx_tready) begin
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_tx = exp_tx.pop_front();
                    check("tx_data", 64'(tx_tdata), 64'(mon_tx.data));
                    check("tx_keep", 64'(tx_tkeep), 64'(mon_tx.keep));
                end
            end
            if (mrd_tready) begin
                pulse_cnt++;
                check("mrd_outside_readback", 64'(in_rb), 64'd1);
                check("mrd_with_tx_tvalid", 64'(tx_tvalid), 64'd0);
            end
            if (done) done_cnt++;
        end
    end

    // One capture + read-back; optional abort, ignored commands, backpressure
    // and reset in TX.
    task automatic capture(input int pre, input bit coinc, input int abort_at,
                           input bit arm_mid, input int cfg_mid, input int bp,
                           input bit rst_tx);
        int left, snap_rd, done0, pulse0, cnt, post, bp_left, guard;
        bit fin, seen;
        logic [MDW-1:0] d, hold_d;
        logic [3:0] hold_k;

        left    = m_fwd;
        snap_rd = m_rd;
        done0   = done_cnt;
        pulse0  = pulse_cnt;
        arm = 1'b1;
        tick();
        arm = 1'b0;

        cnt = 0;
        while (cnt < pre) begin
            sti_tvalid = ($urandom_range(0, 3) != 0);
            d = $urandom();
            sti_tdata = d;
            arm = arm_mid && (cnt == 0);
            if (sti_tvalid) begin
                model_write(d, 1'b0);
                cnt++;
            end
            tick();
        end
        arm = 1'b0;

        run = 1'b1;
        sti_tvalid = coinc;
        d = $urandom();
        sti_tdata = d;
        if (coinc) model_write(d, 1'b0);
        tick();

        post = 0;
        fin  = 0;
        while (!fin) begin
            run = 1'($urandom_range(0, 1));
            sti_tvalid = ($urandom_range(0, 3) != 0);
            d = $urandom();
            sti_tdata = d;
            cfg_wr = 1'b0;
            arm = arm_mid && (post == 2);
            if (cfg_mid >= 0 && post == 1) begin
                cfg_wr  = 1'b1;
                cfg_fwd = CW'(cfg_mid);
                cfg_rd  = CW'(m_rd);
                m_fwd   = cfg_mid;
            end
            if (abort_at >= 0 && post == abort_at) begin
                abort = 1'b1;
                sti_tvalid = 1'b1;
                tick();
                abort = 1'b0;
                sti_tvalid = 1'b0;
                run = 1'b0;
                arm = 1'b0;
                check_idle("abort");
                repeat (3) tick();
                check("abort_no_done", 64'(done_cnt - done0), 64'd0);
                check("abort_writes_drained", 64'(exp_wr.size()), 64'd0);
                return;
            end
            if (sti_tvalid) begin
                if (left == 0) begin
                    model_write(d, 1'b1);
                    fin = 1;
                end else begin
                    model_write(d, 1'b0);
                    left--;
                    post++;
                end
            end
            tick();
        end
        cfg_wr = 1'b0;
        run = 1'b0;
        arm = 1'b0;
        sti_tvalid = 1'b0;

        // Read-back starts at the post-capture address.
        for (int k = 0; k <= snap_rd; k++)
            exp_tx.push_back('{data: model_mem[(model_wa + k) % DEPTH], keep: 4'h7});
        in_rb   = 1;
        bp_left = bp;
        seen    = 0;
        guard   = 0;
        hold_d  = '0;
        hold_k  = '0;
        while (1) begin
            tx_tready = (bp_left > 0 || rst_tx) ? 1'b0 : 1'($urandom_range(0, 1));
            sti_tvalid = 1'($urandom_range(0, 1));
            sti_tdata = $urandom();
            @(negedge clk);
            if (done_cnt != done0) break;
            if (tx_tvalid && rst_tx) begin
                @(posedge clk);
                #1;
                rst = 1'b1;
                sti_tvalid = 1'b0;
                tick();
                rst = 1'b0;
                check_idle("rst_tx");
                check("rst_tx_tdata", 64'(tx_tdata), 64'd0);
                check("rst_tx_tkeep", 64'(tx_tkeep), 64'd0);
                check("rst_mwr_tdata", 64'(mwr_tdata), 64'd0);
                exp_tx.delete();
                m_fwd = 0;
                m_rd  = 0;
                in_rb = 0;
                repeat (2) tick();
                check("rst_no_done", 64'(done_cnt - done0), 64'd0);
                return;
            end
            if (tx_tvalid && bp_left > 0) begin
                if (!seen) begin
                    seen   = 1;
                    hold_d = tx_tdata;
                    hold_k = tx_tkeep;
                end else begin
                    check("bp_tdata_stable", 64'(tx_tdata), 64'(hold_d));
                    check("bp_tkeep_stable", 64'(tx_tkeep), 64'(hold_k));
                    check("bp_no_mrd", 64'(pulse_cnt - pulse0), 64'd0);
                end
                bp_left--;
            end
            guard++;
            if (guard > 500) begin
                check("readback_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        tx_tready  = 1'b0;
        sti_tvalid = 1'b0;
        in_rb = 0;
        repeat (2) tick();
        check("done_pulses", 64'(done_cnt - done0), 64'd1);
        check("mrd_pulses", 64'(pulse_cnt - pulse0), 64'(snap_rd));
        check("tx_drained", 64'(exp_tx.size()), 64'd0);
        check("wr_drained", 64'(exp_wr.size()), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'hC0DE_0000 | 32'(i);
        repeat (3) tick();
        check_idle("reset");
        check("reset_mwr_tdata", 64'(mwr_tdata), 64'd0);
        check("reset_tx_tdata", 64'(tx_tdata), 64'd0);
        check("reset_tx_tkeep", 64'(tx_tkeep), 64'd0);
        rst = 1'b0;
        mon_en = 1;
        tick();

        do_cfg(3, 1);
        capture(5, 1, -1, 0, -1, 0, 0);
        do_cfg(0, 2);
        capture(3, 1, -1, 0, -1, 0, 0);
        do_cfg(2, 3);
        capture(2, 0, -1, 0, -1, 10, 0);
        do_cfg(4, 1);
        capture(3, 0, -1, 1, 9, 0, 0);
        capture(2, 0, -1, 0, -1, 0, 0);
        do_cfg(7, 0);
        capture(4, 0, 2, 0, -1, 0, 0);
        do_cfg(2, 3);
        capture(3, 0, -1, 0, -1, 0, 1);
        capture(1, 1, -1, 0, -1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            do_cfg(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
            capture(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), -1, 0, -1,
                    int'($urandom_range(0, 3)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
